// File: rtl/score_arbiter.sv
// score_arbiter: round-robin arbiter feeding a saturating 4-digit BCD score accumulator with high-score tracking.
module score_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic [3:0]  req,
  input  logic [63:0] points,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        saturated
);
  typedef enum logic [1:0] {IDLE, LATCH, ADD, HICHK} state_t;
  state_t state_q, state_d;
  logic [1:0] rr_q, rr_d, sel;
  logic [15:0] add_q, add_d, score_q, score_d, hi_q, hi_d, sum;
  logic [3:0] grant_q, grant_d;
  logic sat_q, sat_d, busy_q, found, cout;
  function automatic logic [15:0] clamp(input logic [15:0] p);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[15-4*k -: 4] = p[15-4*k -: 4] > 4'd9 ? 4'd9 : p[15-4*k -: 4];
    return r;
  endfunction
  // Digits ripple from ones at [15:12] toward thousands at [3:0]
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0] s;
    logic c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = {1'b0, a[15-4*k -: 4]} + {1'b0, b[15-4*k -: 4]} + {4'b0, c};
      c = s > 5'd9;
      r[15-4*k -: 4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return {c, r};
  endfunction
  function automatic logic [15:0] num(input logic [15:0] x);
    return {x[3:0], x[7:4], x[11:8], x[15:12]};
  endfunction
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      add_q   <= '0;
      score_q <= '0;
      hi_q    <= '0;
      grant_q <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      add_q   <= add_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      grant_q <= grant_d;
      sat_q   <= sat_d;
      busy_q  <= state_d != IDLE;
    end
  end
  // Lowest offset from the pointer wins, so scan offsets from high to low
  always_comb begin
    sel = rr_q;
    for (int k = 3; k >= 0; k--) if (req[rr_q + 2'(k)]) sel = rr_q + 2'(k);
    found = |req;
    {cout, sum} = bcd_add(score_q, add_q);
  end
  always_comb begin
    state_d = clear ? IDLE :
              state_q == IDLE  ? (found ? LATCH : IDLE) :
              state_q == LATCH ? ADD :
              state_q == ADD   ? HICHK : IDLE;
  end
  always_comb begin
    rr_d    = rr_q;
    add_d   = add_q;
    score_d = score_q;
    hi_d    = hi_q;
    sat_d   = sat_q;
    grant_d = '0;
    if (clear) begin
      score_d = '0;
      sat_d   = 1'b0;
    end else if (state_q == IDLE && found) begin
      add_d   = clamp(points[{sel, 4'b0} +: 16]);
      grant_d = 4'b1 << sel;
      rr_d    = sel + 2'd1;
    end else if (state_q == ADD) begin
      score_d = cout ? 16'h9999 : sum;
      sat_d   = sat_q | cout;
    end else if (state_q == HICHK) begin
      hi_d = num(score_q) > num(hi_q) ? score_q : hi_q;
    end
  end
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign score      = score_q;
  assign high_score = hi_q;
  assign saturated  = sat_q;
endmodule

// File: tb/tb_score_arbiter.sv
// tb_score_arbiter: decimal-arithmetic reference model checked every cycle, plus literal expectations for key scenarios.
module tb_score_arbiter;
  logic clock = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] points = '0;
  logic [3:0] grant;
  logic busy, saturated;
  logic [15:0] score, high_score;
  int checks = 0, failures = 0;
  int m_score = 0, m_hi = 0, m_sat = 0, m_rr = 0, m_phase = 0, m_add = 0;
  logic [3:0] m_grant = '0;
  logic [3:0] order[$];
  score_arbiter dut (
    .clock(clock), .reset(reset), .clear(clear), .req(req), .points(points),
    .grant(grant), .busy(busy), .score(score), .high_score(high_score), .saturated(saturated)
  );
  always #5 clock = ~clock;
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v % 10);
    r[11:8]  = 4'((v / 10) % 10);
    r[7:4]   = 4'((v / 100) % 10);
    r[3:0]   = 4'(v / 1000);
    return r;
  endfunction
  function automatic int dec(input logic [15:0] p);
    int v, w, d;
    v = 0;
    w = 1;
    for (int k = 0; k < 4; k++) begin
      d = int'(p[15-4*k -: 4]);
      v += (d > 9 ? 9 : d) * w;
      w *= 10;
    end
    return v;
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      m_score = 0; m_hi = 0; m_sat = 0; m_rr = 0; m_phase = 0; m_grant = '0;
    end else begin
      m_grant = '0;
      if (clear) begin
        m_score = 0; m_sat = 0; m_phase = 0;
      end else if (m_phase == 0) begin
        for (int k = 3; k >= 0; k--) if (req[(m_rr + k) % 4]) m_grant = 4'b1 << ((m_rr + k) % 4);
        if (m_grant != 0) begin
          for (int i = 0; i < 4; i++) if (m_grant[i]) begin
            m_add = dec(points[16*i +: 16]);
            m_rr = (i + 1) % 4;
          end
          m_phase = 1;
        end
      end else if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2) begin
        m_score += m_add;
        if (m_score > 9999) begin m_score = 9999; m_sat = 1; end
        m_phase = 3;
      end else begin
        if (m_score > m_hi) m_hi = m_score;
        m_phase = 0;
      end
    end
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    #1;
    chk("grant", {12'b0, grant}, {12'b0, m_grant});
    chk("busy", {15'b0, busy}, {15'b0, m_phase != 0});
    chk("score", score, to_bcd(m_score));
    chk("high_score", high_score, to_bcd(m_hi));
    chk("saturated", {15'b0, saturated}, 16'(m_sat));
  end
  task automatic run(input logic [3:0] mask, input logic [63:0] p);
    @(negedge clock);
    points = p;
    req = mask;
    for (int c = 0; c < 60 && req != 0; c++) begin
      @(negedge clock);
      if (grant != 0) order.push_back(grant);
      req &= ~grant;
    end
    chk("grant_timeout", {12'b0, req}, 16'h0);
    req = '0;
    repeat (3) @(negedge clock);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("lit_reset_score", score, 16'h0000);
    run(4'b0001, 64'h5200);
    chk("lit_single_grant", {12'b0, order[0]}, 16'h0001);
    chk("lit_single_score", score, 16'h5200);
    chk("lit_single_hi", high_score, 16'h5200);
    do_clear();
    run(4'b0001, 64'h9990);
    run(4'b0010, 64'h1000_0000);
    chk("lit_carry_1000", score, 16'h0001);
    chk("lit_carry_nosat", {15'b0, saturated}, 16'h0);
    do_clear();
    run(4'b0100, 64'h0999_0000_0000);
    run(4'b1000, 64'h5100_0000_0000_0000);
    chk("lit_sat_score", score, 16'h9999);
    chk("lit_sat_flag", {15'b0, saturated}, 16'h1);
    run(4'b0001, 64'h0);
    chk("lit_sat_hold", score, 16'h9999);
    do_reset();
    order.delete();
    run(4'b1111, 64'h1000_1000_1000_1000);
    run(4'b1111, 64'h1000_1000_1000_1000);
    for (int i = 0; i < 8; i++) chk("lit_rr_order", {12'b0, order[i]}, 16'(4'b1 << (i % 4)));
    chk("lit_rr_score", score, 16'h8000);
    do_reset();
    run(4'b0001, 64'h0400);
    @(negedge clock);
    points = 64'h5000;
    req = 4'b0001;
    for (int c = 0; c < 20 && grant == 0; c++) @(negedge clock);
    req = '0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("lit_clr_score", score, 16'h0000);
    chk("lit_clr_busy", {15'b0, busy}, 16'h0);
    order.delete();
    repeat (6) begin
      @(negedge clock);
      if (grant != 0) order.push_back(grant);
    end
    chk("lit_clr_nogrant", 16'(order.size()), 16'h0);
    chk("lit_clr_hi", high_score, 16'h0400);
    do_reset();
    run(4'b0010, 64'h0800_0000);
    do_clear();
    run(4'b0100, 64'h0300_0000_0000);
    chk("lit_hold_score", score, 16'h0300);
    chk("lit_hold_hi", high_score, 16'h0800);
    do_reset();
    run(4'b0001, 64'h0C00);
    chk("lit_clamp_tens", score, 16'h0900);
    run(4'b0010, 64'hC00C_0000);
    chk("lit_clamp_mix", score, 16'h9909);
    @(negedge clock);
    reset = 1'b1;
    clear = 1'b1;
    req = 4'b0100;
    points = 64'h0000_1000_0000_0000;
    @(negedge clock);
    chk("lit_rst_score", score, 16'h0000);
    chk("lit_rst_hi", high_score, 16'h0000);
    chk("lit_rst_grant", {12'b0, grant}, 16'h0);
    chk("lit_rst_busy", {15'b0, busy}, 16'h0);
    reset = 1'b0;
    clear = 1'b0;
    req = '0;
    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
